// File: rtl/alu_issue_unit.sv
// Initiator side of the ALU interface: decodes and registers a request, drives the
// external combinational ALU, then captures its result and flags into a response register.
module alu_issue_unit #(
  parameter int DATA_W  = 64,
  parameter int TAG_W   = 4,
  parameter int COUNT_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [2:0]         req_op,
  input  logic [DATA_W-1:0]  req_a,
  input  logic [DATA_W-1:0]  req_b,
  input  logic [TAG_W-1:0]   req_tag,
  output logic [DATA_W-1:0]  alu_a,
  output logic [DATA_W-1:0]  alu_b,
  output logic [3:0]         alu_control,
  input  logic [DATA_W-1:0]  alu_out,
  input  logic               alu_carry,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [DATA_W-1:0]  rsp_result,
  output logic               rsp_ovf,
  output logic               rsp_zero,
  output logic               rsp_err,
  output logic [TAG_W-1:0]   rsp_tag,
  output logic [COUNT_W-1:0] op_count,
  output logic [1:0]         fsm_state
);

  // Handshake: a transfer happens on a rising edge where valid and ready are both high;
  // valid never depends on ready, and a presented response holds until it transfers.

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  localparam logic [2:0] OP_AND   = 3'd0;
  localparam logic [2:0] OP_OR    = 3'd1;
  localparam logic [2:0] OP_ADD   = 3'd2;
  localparam logic [2:0] OP_SUB   = 3'd3;
  localparam logic [2:0] OP_PASSB = 3'd4;
  localparam logic [2:0] OP_NOR   = 3'd5;

  logic [1:0]        state;
  logic [2:0]        op_q;
  logic              err_q;
  logic [TAG_W-1:0]  tag_q;
  logic [3:0]        ctrl_dec;
  logic              legal;
  logic              accept;
  logic              sub_ovf;
  logic              ovf_next;
  logic [DATA_W-1:0] result_next;

  assign fsm_state = state;

  always_comb begin
    legal    = 1'b1;
    ctrl_dec = 4'b0000;
    case (req_op)
      OP_AND:   ctrl_dec = 4'b0000;
      OP_OR:    ctrl_dec = 4'b0001;
      OP_ADD:   ctrl_dec = 4'b0010;
      OP_SUB:   ctrl_dec = 4'b0110;
      OP_PASSB: ctrl_dec = 4'b0111;
      OP_NOR:   ctrl_dec = 4'b1100;
      default:  legal    = 1'b0;
    endcase
  end

  assign req_ready = rst_n & ((state == IDLE) | ((state == RESP) & rsp_ready));
  assign accept    = req_valid & req_ready;

  // The ALU only refreshes its carry on ADD, so every other op must mask it.
  assign sub_ovf = (alu_a[DATA_W-1] & ~alu_b[DATA_W-1] & ~alu_out[DATA_W-1]) |
                   (~alu_a[DATA_W-1] & alu_b[DATA_W-1] & alu_out[DATA_W-1]);

  always_comb begin
    ovf_next = 1'b0;
    if (!err_q) begin
      if (op_q == OP_ADD)      ovf_next = alu_carry;
      else if (op_q == OP_SUB) ovf_next = sub_ovf;
    end
  end

  assign result_next = err_q ? '0 : alu_out;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      op_q        <= '0;
      err_q       <= 1'b0;
      tag_q       <= '0;
      alu_a       <= '0;
      alu_b       <= '0;
      alu_control <= '0;
      rsp_valid   <= 1'b0;
      rsp_result  <= '0;
      rsp_ovf     <= 1'b0;
      rsp_zero    <= 1'b0;
      rsp_err     <= 1'b0;
      rsp_tag     <= '0;
      op_count    <= '0;
    end else begin
      if (accept) begin
        alu_a       <= legal ? req_a : '0;
        alu_b       <= legal ? req_b : '0;
        alu_control <= ctrl_dec;
        op_q        <= req_op;
        err_q       <= ~legal;
        tag_q       <= req_tag;
      end
      case (state)
        IDLE: begin
          if (accept) state <= EXEC;
        end
        EXEC: begin
          rsp_result <= result_next;
          rsp_ovf    <= ovf_next;
          rsp_zero   <= (result_next == '0);
          rsp_err    <= err_q;
          rsp_tag    <= tag_q;
          rsp_valid  <= 1'b1;
          state      <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            op_count  <= op_count + {{(COUNT_W-1){1'b0}}, 1'b1};
            rsp_valid <= 1'b0;
            state     <= accept ? EXEC : IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue_unit.sv
// Directed bench for alu_issue_unit with a behavioural ALU attached to its alu_* port,
// including a carry that only updates on ADD so stale-carry masking is exercised.
module tb_alu_issue_unit;

  localparam int DW = 64;
  localparam int TW = 4;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid;
  logic          req_ready;
  logic [2:0]    req_op;
  logic [DW-1:0] req_a;
  logic [DW-1:0] req_b;
  logic [TW-1:0] req_tag;
  logic [DW-1:0] alu_a;
  logic [DW-1:0] alu_b;
  logic [3:0]    alu_control;
  logic [DW-1:0] alu_out;
  logic          alu_carry;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_result;
  logic          rsp_ovf;
  logic          rsp_zero;
  logic          rsp_err;
  logic [TW-1:0] rsp_tag;
  logic [CW-1:0] op_count;
  logic [1:0]    fsm_state;

  int vectors = 0;
  int miscompares = 0;
  int exp_count = 0;

  alu_issue_unit #(.DATA_W(DW), .TAG_W(TW), .COUNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .req_tag(req_tag),
    .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control),
    .alu_out(alu_out), .alu_carry(alu_carry),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_ovf(rsp_ovf), .rsp_zero(rsp_zero), .rsp_err(rsp_err), .rsp_tag(rsp_tag),
    .op_count(op_count), .fsm_state(fsm_state)
  );

  always #5 clk = ~clk;

  // Behavioural ALU
  logic [DW-1:0] sum;
  logic          add_ovf;
  logic          carry_hold = 1'b0;

  assign sum     = alu_a + alu_b;
  assign add_ovf = (alu_a[DW-1] == alu_b[DW-1]) && (sum[DW-1] != alu_a[DW-1]);

  always_comb begin
    alu_out = '0;
    case (alu_control)
      4'b0000: alu_out = alu_a & alu_b;
      4'b0001: alu_out = alu_a | alu_b;
      4'b0010: alu_out = sum;
      4'b0110: alu_out = alu_a - alu_b;
      4'b0111: alu_out = alu_b;
      4'b1100: alu_out = ~(alu_a | alu_b);
      default: alu_out = '0;
    endcase
  end

  assign alu_carry = (alu_control == 4'b0010) ? add_ovf : carry_hold;

  always @(posedge clk) begin
    if (alu_control == 4'b0010) carry_hold <= add_ovf;
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", name, got, exp);
    end
  endtask

  // Starts and ends just after a rising edge; the request is accepted on the last edge.
  task automatic issue(input logic [2:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b,
                       input logic [TW-1:0] tag);
    int n;
    req_op = op; req_a = a; req_b = b; req_tag = tag; req_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 20) begin
      n++;
      @(negedge clk);
    end
    chk("accept_ready", 64'(req_ready), 64'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic expect_rsp(input string nm, input logic [3:0] ctrl, input logic [DW-1:0] res,
                            input logic ovf, input logic zero, input logic err,
                            input logic [TW-1:0] tag);
    @(negedge clk);
    chk($sformatf("%s_exec_valid", nm), 64'(rsp_valid), 64'd0);
    chk($sformatf("%s_exec_ready", nm), 64'(req_ready), 64'd0);
    chk($sformatf("%s_control", nm), 64'(alu_control), 64'(ctrl));
    @(negedge clk);
    chk($sformatf("%s_valid", nm), 64'(rsp_valid), 64'd1);
    chk($sformatf("%s_result", nm), rsp_result, res);
    chk($sformatf("%s_ovf", nm), 64'(rsp_ovf), 64'(ovf));
    chk($sformatf("%s_zero", nm), 64'(rsp_zero), 64'(zero));
    chk($sformatf("%s_err", nm), 64'(rsp_err), 64'(err));
    chk($sformatf("%s_tag", nm), 64'(rsp_tag), 64'(tag));
    @(posedge clk); #1;
  endtask

  task automatic retire(input string nm);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    exp_count = (exp_count + 1) % (1 << CW);
    @(negedge clk);
    chk($sformatf("%s_retired_valid", nm), 64'(rsp_valid), 64'd0);
    chk($sformatf("%s_count", nm), 64'(op_count), 64'(exp_count));
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0;
    req_op = '0; req_a = '0; req_b = '0; req_tag = '0;
    #2;
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_op_count", 64'(op_count), 64'd0);
    chk("rst_alu_control", 64'(alu_control), 64'd0);
    chk("rst_alu_a", alu_a, 64'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_req_ready", 64'(req_ready), 64'd1);
    @(posedge clk); #1;

    issue(3'd2, 64'd5, 64'd7, 4'd3);
    expect_rsp("add_small", 4'b0010, 64'd12, 1'b0, 1'b0, 1'b0, 4'd3);
    retire("add_small");

    issue(3'd2, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 4'd1);
    expect_rsp("add_ovf", 4'b0010, 64'h8000_0000_0000_0000, 1'b1, 1'b0, 1'b0, 4'd1);
    retire("add_ovf");

    issue(3'd3, 64'h8000_0000_0000_0000, 64'd1, 4'd2);
    expect_rsp("sub_ovf", 4'b0110, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b0, 4'd2);
    retire("sub_ovf");

    issue(3'd0, 64'd0, 64'd0, 4'd4);
    expect_rsp("and_zero", 4'b0000, 64'd0, 1'b0, 1'b1, 1'b0, 4'd4);
    retire("and_zero");

    issue(3'd6, 64'd9, 64'd3, 4'hA);
    chk("illegal_alu_a", alu_a, 64'd0);
    chk("illegal_alu_b", alu_b, 64'd0);
    expect_rsp("illegal", 4'b0000, 64'd0, 1'b0, 1'b1, 1'b1, 4'hA);
    retire("illegal");

    issue(3'd5, 64'd0, 64'd0, 4'd6);
    expect_rsp("nor", 4'b1100, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b0, 4'd6);
    retire("nor");

    issue(3'd4, 64'd1, 64'h55, 4'd8);
    expect_rsp("passb", 4'b0111, 64'h55, 1'b0, 1'b0, 1'b0, 4'd8);
    retire("passb");

    // Backpressure, then retire and accept on the same edge.
    issue(3'd1, 64'hF0, 64'h0F, 4'd5);
    expect_rsp("or", 4'b0001, 64'hFF, 1'b0, 1'b0, 1'b0, 4'd5);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_valid", 64'(rsp_valid), 64'd1);
      chk("hold_req_ready", 64'(req_ready), 64'd0);
      chk("hold_result", rsp_result, 64'hFF);
      chk("hold_tag", 64'(rsp_tag), 64'd5);
      @(posedge clk); #1;
    end
    req_op = 3'd2; req_a = 64'd2; req_b = 64'd3; req_tag = 4'd7;
    req_valid = 1'b1; rsp_ready = 1'b1;
    @(negedge clk);
    chk("b2b_req_ready", 64'(req_ready), 64'd1);
    @(posedge clk); #1;
    req_valid = 1'b0; rsp_ready = 1'b0;
    exp_count = (exp_count + 1) % (1 << CW);
    expect_rsp("b2b", 4'b0010, 64'd5, 1'b0, 1'b0, 1'b0, 4'd7);
    chk("b2b_count", 64'(op_count), 64'(exp_count));
    retire("b2b");

    // Reset while an operation is in EXEC.
    issue(3'd2, 64'd1, 64'd1, 4'd1);
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    exp_count = 0;
    chk("midrst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("midrst_op_count", 64'(op_count), 64'd0);
    chk("midrst_req_ready", 64'(req_ready), 64'd0);
    chk("midrst_alu_a", alu_a, 64'd0);
    chk("midrst_rsp_tag", 64'(rsp_tag), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    issue(3'd3, 64'd10, 64'd3, 4'd2);
    expect_rsp("post_rst_sub", 4'b0110, 64'd7, 1'b0, 1'b0, 1'b0, 4'd2);
    retire("post_rst_sub");

    // Fifteen more retirements take the 4-bit counter through its wrap to 0.
    for (int i = 0; i < 15; i++) begin
      issue(3'd2, 64'(i), 64'(i + 1), 4'(i));
      expect_rsp("loop_add", 4'b0010, 64'(2 * i + 1), 1'b0, 1'b0, 1'b0, 4'(i));
      retire("loop_add");
    end
    chk("wrap_count", 64'(op_count), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
